// File: rtl/multicycle_addsub_n.sv
// multicycle_addsub_n: sequential N-operand signed add/subtract engine.
// Operands and op bits are captured when start is accepted; one operand is
// folded into the accumulator per RUN cycle. done pulses for one cycle when
// the result is final. The ovf flag is sticky and records a signed overflow
// on any step.
// Optional build macro SATURATE_EN: an overflowing step clamps the
// accumulator to +MAX or MIN instead of wrapping.
module multicycle_addsub_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       op_sel,
  input  logic [N*WIDTH-1:0] ops_in,
  output logic [WIDTH-1:0]   result,
  output logic               ovf,
  output logic               busy,
  output logic               done
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);

  logic [1:0]                 state;
  logic [N-1:0][WIDTH-1:0]    ops_q;
  logic [N-1:0]               sel_q;
  logic [CNT_W-1:0]           idx;
  logic [WIDTH-1:0]           acc;
  logic                       ovf_q;

  logic [WIDTH-1:0]           opnd;
  logic                       sub;
  logic [WIDTH-1:0]           sum;
  logic                       step_ovf;
  logic [WIDTH-1:0]           acc_nxt;

  // One accumulate step: current operand, raw sum, overflow and the next acc
  always_comb begin
    opnd     = ops_q[idx];
    sub      = sel_q[idx];
    sum      = sub ? (acc - opnd) : (acc + opnd);
    // add overflows when the operands agree in sign and the sum does not;
    // sub overflows when the operands differ in sign and the sum leaves acc's sign
    if (sub)
      step_ovf = (acc[WIDTH-1] != opnd[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    else
      step_ovf = (acc[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
`ifdef SATURATE_EN
    // overflow direction always follows the sign of acc before the step
    acc_nxt = step_ovf ? (acc[WIDTH-1] ? SMIN : SMAX) : sum;
`else
    acc_nxt = sum;
`endif
  end

  // Control FSM plus the datapath registers it sequences
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ops_q <= '0;
      sel_q <= '0;
      idx   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ops_q <= ops_in;
            sel_q <= op_sel;
            idx   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          ovf_q <= ovf_q | step_ovf;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result = acc;
  assign ovf    = ovf_q;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_multicycle_addsub_n.sv
// Directed bench for multicycle_addsub_n (WIDTH=8, N=4 plus an N=1 instance).
// Expectations follow the SATURATE_EN macro when it is defined.
module tb_multicycle_addsub_n;
  logic        clock = 1'b0;
  logic        reset;
  logic        start, start1;
  logic [3:0]  op_sel;
  logic [0:0]  op_sel1;
  logic [31:0] ops_in;
  logic [7:0]  ops_in1;
  logic [7:0]  result, result1;
  logic        ovf, busy, done, ovf1, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multicycle_addsub_n #(.WIDTH(8), .N(4)) u_dut (
    .clock(clock), .reset(reset), .start(start), .op_sel(op_sel), .ops_in(ops_in),
    .result(result), .ovf(ovf), .busy(busy), .done(done)
  );

  multicycle_addsub_n #(.WIDTH(8), .N(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .op_sel(op_sel1), .ops_in(ops_in1),
    .result(result1), .ovf(ovf1), .busy(busy1), .done(done1)
  );

  // advance past one rising edge; outputs are then settled for that edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // one-cycle start pulse, then wait (bounded) for done; seen=0 on timeout
  task automatic run_op(input logic [31:0] ops, input logic [3:0] sel, output logic seen);
    ops_in = ops; op_sel = sel; start = 1'b1;
    tick();
    start = 1'b0; ops_in = 32'hDEAD_BEEF; op_sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; start1 = 0; op_sel = '0; op_sel1 = '0; ops_in = '0; ops_in1 = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if ({result, ovf, busy, done} !== 11'b0) begin errors++;
      $display("FAIL reset_n4: got res=%h ovf=%b busy=%b done=%b, want 00 0 0 0", result, ovf, busy, done); end
    checks++; if ({result1, ovf1, busy1, done1} !== 11'b0) begin errors++;
      $display("FAIL reset_n1: got res=%h ovf=%b busy=%b done=%b, want 00 0 0 0", result1, ovf1, busy1, done1); end
  endtask

  task automatic test_add_timing();
    ops_in = {8'h02, 8'hFF, 8'h02, 8'h01}; op_sel = 4'b0000; start = 1'b1;
    tick();                               // accept edge 0
    start = 1'b0; ops_in = 32'h5555_5555; op_sel = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
        $display("FAIL add_busy_edge%0d: got busy=%b done=%b, want 1 0", k, busy, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || result !== 8'h04 || ovf !== 1'b0) begin errors++;
      $display("FAIL add_done: got done=%b busy=%b res=%h ovf=%b, want 1 0 04 0", done, busy, result, ovf); end
    tick();
    checks++; if (done !== 1'b0 || result !== 8'h04) begin errors++;
      $display("FAIL add_hold: got done=%b res=%h, want 0 04", done, result); end
  endtask

  task automatic test_mixed();
    logic seen;
    run_op({8'h04, 8'h01, 8'h01, 8'hFE}, 4'b1010, seen);
    checks++; if (!seen || result !== 8'hFA || ovf !== 1'b0) begin errors++;
      $display("FAIL mixed: got seen=%b res=%h ovf=%b, want 1 fa 0", seen, result, ovf); end
  endtask

  task automatic test_overflow();
    logic seen;
    logic [7:0] e_pos, e_neg, e_sticky;
`ifdef SATURATE_EN
    e_pos = 8'h7F; e_neg = 8'h80; e_sticky = 8'h7F;
`else
    e_pos = 8'h80; e_neg = 8'h7F; e_sticky = 8'h81;
`endif
    run_op({8'h00, 8'h00, 8'h01, 8'h7F}, 4'b0000, seen);
    checks++; if (!seen || result !== e_pos || ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_pos: got seen=%b res=%h ovf=%b, want 1 %h 1", seen, result, ovf, e_pos); end
    // -128 - 1 overflows negative
    run_op({8'h00, 8'h00, 8'h01, 8'h80}, 4'b0010, seen);
    checks++; if (!seen || result !== e_neg || ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_neg: got seen=%b res=%h ovf=%b, want 1 %h 1", seen, result, ovf, e_neg); end
    // overflow on step 1, later steps clean: flag must stay set
    run_op({8'h00, 8'hFF, 8'h01, 8'h7F}, 4'b0100, seen);
    checks++; if (!seen || result !== e_sticky || ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky: got seen=%b res=%h ovf=%b, want 1 %h 1", seen, result, ovf, e_sticky); end
    // a clean op after an overflowing one clears the flag
    run_op({8'h00, 8'h00, 8'h00, 8'h03}, 4'b0000, seen);
    checks++; if (!seen || result !== 8'h03 || ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clear: got seen=%b res=%h ovf=%b, want 1 03 0", seen, result, ovf); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic any_done;
    ops_in = {8'h02, 8'hFF, 8'h02, 8'h01}; op_sel = 4'b0000; start = 1'b1;
    tick();                               // edge 0
    start = 1'b0;
    tick();                               // edge 1, acc = 01
    reset = 1'b1;
    tick();                               // edge 2 sampled with reset
    reset = 1'b0;
    checks++; if ({result, ovf, busy, done} !== 11'b0) begin errors++;
      $display("FAIL midreset: got res=%h ovf=%b busy=%b done=%b, want 00 0 0 0", result, ovf, busy, done); end
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); any_done |= done; end
    checks++; if (any_done !== 1'b0) begin errors++;
      $display("FAIL midreset_nodone: got done seen=%b, want 0", any_done); end
    run_op({8'h02, 8'hFF, 8'h02, 8'h01}, 4'b0000, seen);
    checks++; if (!seen || result !== 8'h04 || ovf !== 1'b0) begin errors++;
      $display("FAIL midreset_rerun: got seen=%b res=%h ovf=%b, want 1 04 0", seen, result, ovf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] set_ops [3];
    logic [3:0]  set_sel [3];
    logic [7:0]  set_res [3];
    logic        set_ovf [3];
    set_ops[0] = {8'h04, 8'h03, 8'h02, 8'h01}; set_sel[0] = 4'b0000; set_res[0] = 8'h0A; set_ovf[0] = 1'b0;
    set_ops[1] = {8'h01, 8'h05, 8'h20, 8'h10}; set_sel[1] = 4'b0011; set_res[1] = 8'hD6; set_ovf[1] = 1'b0;
    set_ops[2] = {8'h00, 8'h00, 8'h7F, 8'h7F}; set_sel[2] = 4'b0000; set_ovf[2] = 1'b1;
`ifdef SATURATE_EN
    set_res[2] = 8'h7F;
`else
    set_res[2] = 8'hFE;
`endif
    start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c % 5 == 0) begin ops_in = set_ops[c/5]; op_sel = set_sel[c/5]; end
      else begin ops_in = 32'hA5A5_A5A5 ^ 32'(c * 32'h0101_0101); op_sel = 4'(c); end
      tick();
      if (busy && done) begin checks++; errors++;
        $display("FAIL b2b_busy_done cycle %0d: got busy=1 done=1, want not both", c); end
      if (c % 5 == 4) begin
        checks++; if (done !== 1'b1 || result !== set_res[c/5] || ovf !== set_ovf[c/5]) begin errors++;
          $display("FAIL b2b_op%0d: got done=%b res=%h ovf=%b, want 1 %h %b", c/5, done, result, ovf, set_res[c/5], set_ovf[c/5]); end
      end else begin
        checks++; if (done !== 1'b0) begin errors++;
          $display("FAIL b2b_nodone cycle %0d: got done=%b, want 0", c, done); end
      end
    end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done); end
  endtask

  task automatic test_n1();
    logic [7:0] e_neg;
`ifdef SATURATE_EN
    e_neg = 8'h7F;
`else
    e_neg = 8'h80;
`endif
    ops_in1 = 8'h80; op_sel1 = 1'b1; start1 = 1'b1;
    tick();                               // accept
    start1 = 1'b0; ops_in1 = 8'h11; op_sel1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++;
      $display("FAIL n1_busy: got busy=%b done=%b, want 1 0", busy1, done1); end
    tick();
    checks++; if (done1 !== 1'b1 || result1 !== e_neg || ovf1 !== 1'b1) begin errors++;
      $display("FAIL n1_negmin: got done=%b res=%h ovf=%b, want 1 %h 1", done1, result1, ovf1, e_neg); end
    ops_in1 = 8'h05; op_sel1 = 1'b0; start1 = 1'b1;   // back-to-back from DONE
    tick();
    start1 = 1'b0;
    tick();
    checks++; if (done1 !== 1'b1 || result1 !== 8'h05 || ovf1 !== 1'b0) begin errors++;
      $display("FAIL n1_add: got done=%b res=%h ovf=%b, want 1 05 0", done1, result1, ovf1); end
    tick();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++;
      $display("FAIL n1_idle: got done=%b busy=%b, want 0 0", done1, busy1); end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_mixed();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop in case a wait ever escapes its bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1);
  end
endmodule
